// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes and fix the result sign on the final iteration.
module mul_div_unit #(
    parameter int N     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_we,
    input  logic         lo_we,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           neg_rem_q, neg_rem_d;
    logic           dbz_q, dbz_d;
    logic [N-1:0]   opnd_q, opnd_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;

    logic [N-1:0]   abs_a, abs_b;
    logic [N:0]     mul_sum, trial;
    logic [2*N-1:0] mul_next, div_next, step, prod;
    logic [N-1:0]   quo, rem;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        abs_a    = (op[0] && inA[N-1]) ? -inA : inA;
        abs_b    = (op[0] && inB[N-1]) ? -inB : inB;
        mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[N-1:1]};
        trial    = {acc_q[2*N-1:N], acc_q[N-1]} - {1'b0, opnd_q};
        div_next = trial[N] ? {acc_q[2*N-2:N-1], acc_q[N-2:0], 1'b0}
                            : {trial[N-1:0], acc_q[N-2:0], 1'b1};
        step     = is_div_q ? div_next : mul_next;
        prod     = neg_q ? -step : step;
        quo      = neg_q ? -step[N-1:0] : step[N-1:0];
        rem      = neg_rem_q ? -step[2*N-1:N] : step[2*N-1:N];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    dbz_d     = 1'b0;
                    neg_d     = op[0] & (inA[N-1] ^ inB[N-1]);
                    neg_rem_d = op[0] & inA[N-1];
                    if (op[1] && inB == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        hi_d    = inA;
                        lo_d    = '1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(N);
                        if (op[1]) begin
                            acc_d  = {{N{1'b0}}, abs_a};
                            opnd_d = abs_b;
                        end else begin
                            acc_d  = {{N{1'b0}}, abs_b};
                            opnd_d = abs_a;
                        end
                    end
                end else begin
                    if (hi_we) hi_d = inA;
                    if (lo_we) lo_d = inA;
                end
            end
            BUSY: begin
                acc_d = step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*N-1:N];
                        lo_d = prod[N-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == BUSY);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: N=32 and N=8 instances checked every cycle against a
// transaction-level model, plus directed vectors with fixed expected results.
module tb_mul_div_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n;
    logic        st[2];
    logic [1:0]  opv[2];
    logic [63:0] av[2], bv[2];
    logic        hw[2], lw[2];

    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    mul_div_unit #(.N(32), .CNT_W(6)) u32 (
        .clock(clock), .reset(rst_n), .start(st[0]), .op(opv[0]),
        .inA(av[0][31:0]), .inB(bv[0][31:0]), .hi_we(hw[0]), .lo_we(lw[0]),
        .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
    );

    mul_div_unit #(.N(8), .CNT_W(4)) u8 (
        .clock(clock), .reset(rst_n), .start(st[1]), .op(opv[1]),
        .inA(av[1][7:0]), .inB(bv[1][7:0]), .hi_we(hw[1]), .lo_we(lw[1]),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_done[2];
    int wid[2];

    // model: 0 idle, 1 computing (m_left cycles to go), 2 result cycle
    int          m_st[2], m_left[2], m_acc[2];
    logic        m_dbz[2];
    logic [63:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
        int          lat;
        string       name;
    } vec_t;
    vec_t tbl[10];

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_op(input int w, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] rhi, output logic [63:0] rlo);
        logic [63:0] mask, p;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a << (64 - w));
        sa = sa >>> (64 - w);
        sb = longint'(b << (64 - w));
        sb = sb >>> (64 - w);
        case (op)
            2'd0: begin p = a * b; rhi = (p >> w) & mask; rlo = p & mask; end
            2'd1: begin p = 64'(sa * sb); rhi = (p >> w) & mask; rlo = p & mask; end
            2'd2: begin rlo = a / b; rhi = a % b; end
            default: begin rlo = 64'(sa / sb) & mask; rhi = 64'(sa % sb) & mask; end
        endcase
    endtask

    task automatic model_step(input int i);
        logic [63:0] mask, a, b;
        mask = (64'd1 << wid[i]) - 64'd1;
        a = av[i] & mask;
        b = bv[i] & mask;
        if (!rst_n) begin
            m_st[i] = 0; m_left[i] = 0; m_dbz[i] = 1'b0; m_hi[i] = '0; m_lo[i] = '0;
            return;
        end
        case (m_st[i])
            0: begin
                if (st[i]) begin
                    m_acc[i]++;
                    m_dbz[i] = 1'b0;
                    if (opv[i][1] && b == 0) begin
                        m_st[i] = 2; m_dbz[i] = 1'b1; m_hi[i] = a; m_lo[i] = mask;
                    end else begin
                        ref_op(wid[i], opv[i], a, b, p_hi[i], p_lo[i]);
                        m_st[i] = 1; m_left[i] = wid[i];
                    end
                end else begin
                    if (hw[i]) m_hi[i] = a;
                    if (lw[i]) m_lo[i] = a;
                end
            end
            1: begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_st[i] = 2; m_hi[i] = p_hi[i]; m_lo[i] = p_lo[i];
                end
            end
            default: m_st[i] = 0;
        endcase
    endtask

    task automatic check_dut(input int i);
        logic        b, d, z;
        logic [63:0] h, l;
        if (i == 0) begin b = busy32; d = done32; z = dbz32; h = {32'd0, hi32}; l = {32'd0, lo32}; end
        else        begin b = busy8;  d = done8;  z = dbz8;  h = {56'd0, hi8};  l = {56'd0, lo8};  end
        n_cmp++;
        if (b !== (m_st[i] == 1) || d !== (m_st[i] == 2) || z !== m_dbz[i] || h !== m_hi[i] || l !== m_lo[i]) begin
            n_bad++;
            $display("FAIL model N=%0d t=%0t: got busy=%b done=%b dbz=%b hi=%h lo=%h expected busy=%b done=%b dbz=%b hi=%h lo=%h",
                     wid[i], $time, b, d, z, h, l, m_st[i] == 1, m_st[i] == 2, m_dbz[i], m_hi[i], m_lo[i]);
        end
    endtask

    // inputs are set before the call; one clock edge elapses; outputs checked at negedge
    task automatic tick();
        model_step(0);
        model_step(1);
        @(negedge clock);
        if (done32) n_done[0]++;
        if (done8)  n_done[1]++;
        check_dut(0);
        check_dut(1);
    endtask

    // start in cycle 0; lat is the cycle in which done is seen
    task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                      input int elat, input string name);
        int lat;
        st[0] = 1'b1; opv[0] = op; av[0] = {32'd0, a}; bv[0] = {32'd0, b};
        tick();
        st[0] = 1'b0; hw[0] = 1'b0; lw[0] = 1'b0;
        av[0] = 64'h5A5A_5A5A; bv[0] = 64'h0; opv[0] = 2'd3;
        lat = 1;
        while (!done32 && lat < 40) begin
            tick();
            lat++;
        end
        check_val({name, " latency"}, 64'(lat), 64'(elat));
        check_val({name, " hi"}, {32'd0, hi32}, {32'd0, ehi});
        check_val({name, " lo"}, {32'd0, lo32}, {32'd0, elo});
        check_val({name, " dbz"}, {63'd0, dbz32}, {63'd0, edbz});
        tick();
        check_val({name, " idle after done"}, {62'd0, busy32, done32}, 64'd0);
    endtask

    initial begin
        wid[0] = 32; wid[1] = 8;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; opv[i] = 2'd0; av[i] = '0; bv[i] = '0; hw[i] = 1'b0; lw[i] = 1'b0;
            m_st[i] = 0; m_left[i] = 0; m_acc[i] = 0; m_dbz[i] = 1'b0;
            m_hi[i] = '0; m_lo[i] = '0; p_hi[i] = '0; p_lo[i] = '0; n_done[i] = 0;
        end

        tbl[0] = '{2'd0, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0, 33, "multu 7*6"};
        tbl[1] = '{2'd1, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  1'b0, 33, "mult -3*5"};
        tbl[2] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0, 33, "multu max*max"};
        tbl[3] = '{2'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'd0,          1'b0, 33, "mult min*min"};
        tbl[4] = '{2'd2, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0, 33, "divu 100/7"};
        tbl[5] = '{2'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0, 33, "div -7/2"};
        tbl[6] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 33, "div min/-1"};
        tbl[7] = '{2'd3, 32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF,  1'b1, 1,  "div 9/0"};
        tbl[8] = '{2'd2, 32'd0,          32'd3,          32'd0,          32'd0,          1'b0, 33, "divu 0/3 clears flag"};
        tbl[9] = '{2'd2, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1, 1,  "divu 5/0"};

        rst_n = 1'b0;
        tick();
        tick();
        check_val("reset outputs", {dbz32, done32, busy32, hi32}, 64'd0);
        check_val("reset lo", {32'd0, lo32}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 10; k++)
            go(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].hi, tbl[k].lo, tbl[k].dbz, tbl[k].lat, tbl[k].name);

        // MTHI / MTLO, then a start in the same cycle as both writes
        hw[0] = 1'b1; av[0] = 64'h1234; tick();
        hw[0] = 1'b0; lw[0] = 1'b1; av[0] = 64'h5678; tick();
        lw[0] = 1'b0;
        check_val("mthi", {32'd0, hi32}, 64'h1234);
        check_val("mtlo", {32'd0, lo32}, 64'h5678);
        hw[0] = 1'b1; lw[0] = 1'b1; av[0] = 64'hAA; tick();
        hw[0] = 1'b0; lw[0] = 1'b0;
        check_val("mthi+mtlo", {hi32, lo32}, 64'h0000_00AA_0000_00AA);
        hw[0] = 1'b1; lw[0] = 1'b1;
        go(2'd2, 32'd50, 32'd5, 32'd0, 32'd10, 1'b0, 33, "start beats writes");

        // start held through the done cycle is not accepted there
        st[0] = 1'b1; opv[0] = 2'd0; av[0] = 64'd2; bv[0] = 64'd3;
        for (int k = 0; k < 40 && !done32; k++) tick();
        check_val("held start done", {32'd0, lo32}, 64'd6);
        opv[0] = 2'd0; av[0] = 64'd5; bv[0] = 64'd5;
        tick();
        check_val("no accept in done", {62'd0, busy32, done32}, 64'd0);
        tick();
        check_val("accept next idle", {62'd0, busy32, done32}, 64'd2);
        st[0] = 1'b0;
        for (int k = 0; k < 40 && !done32; k++) tick();
        check_val("second op result", {32'd0, lo32}, 64'd25);
        tick();

        // abort by reset: start 3*4 at cycle 0, ignored start at 5, reset at 10
        for (int k = 0; k <= 10; k++) begin
            st[0] = (k == 0 || k == 5);
            av[0] = (k == 0) ? 64'd3 : 64'd5;
            bv[0] = (k == 0) ? 64'd4 : 64'd5;
            opv[0] = 2'd0;
            rst_n = (k != 10);
            tick();
        end
        st[0] = 1'b0; rst_n = 1'b1;
        check_val("reset abort busy", {63'd0, busy32}, 64'd0);
        check_val("reset abort hi/lo", {hi32, lo32}, 64'd0);
        n_done[0] = 0;
        for (int k = 0; k < 40; k++) tick();
        check_val("no done after abort", 64'(n_done[0]), 64'd0);

        // random back-to-back traffic on both widths
        for (int i = 0; i < 2; i++) begin n_done[i] = 0; m_acc[i] = 0; end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                st[i]  = ($urandom % 3) != 0;
                opv[i] = 2'($urandom % 4);
                hw[i]  = ($urandom % 4) == 0;
                lw[i]  = ($urandom % 4) == 0;
                av[i]  = {$urandom, $urandom};
                bv[i]  = ($urandom % 6 == 0) ? 64'd0 : {$urandom, $urandom};
                if ($urandom % 8 == 0) begin
                    av[i] = 64'd1 << (wid[i] - 1);
                    bv[i] = '1;
                end
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin st[i] = 1'b0; hw[i] = 1'b0; lw[i] = 1'b0; end
        for (int k = 0; k < 40 && (busy32 || busy8 || done32 || done8); k++) tick();
        check_val("drained", {60'd0, busy32, busy8, done32, done8}, 64'd0);
        check_val("done count N=32", 64'(n_done[0]), 64'(m_acc[0]));
        check_val("done count N=8", 64'(n_done[1]), 64'(m_acc[1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
